// File: rtl/order_book_dispatcher.sv
// In-order command FIFO that launches each command into its per-stock order book.
// Define DISPATCH_STATS_EN to build the saturating dispatch/reject counters.
module order_book_dispatcher #(
  parameter int NUM_STOCKS = 4,
  parameter int STOCK_W    = 6,
  parameter int CMD_W      = 128,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [STOCK_W-1:0]          cmd_stock,
  input  logic [CMD_W-1:0]            cmd_payload,
  output logic [NUM_STOCKS-1:0]       book_start,
  output logic [CMD_W-1:0]            book_cmd,
  input  logic [NUM_STOCKS-1:0]       book_busy,
  output logic                        reject_pulse,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        is_busy,
  output logic [15:0]                 dispatch_count,
  output logic [15:0]                 reject_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [STOCK_W:0] STOCK_LIMIT = (STOCK_W + 1)'(NUM_STOCKS);
  localparam logic [AW:0] FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] SLOT_IDLE  = 2'd0;
  localparam logic [1:0] SLOT_START = 2'd1;
  localparam logic [1:0] SLOT_ARM   = 2'd2;
  localparam logic [1:0] SLOT_RUN   = 2'd3;

  logic [STOCK_W-1:0] stock_mem   [FIFO_DEPTH];
  logic [CMD_W-1:0]   payload_mem [FIFO_DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic                  cmd_fire;
  logic                  stock_ok;
  logic                  push;
  logic                  reject;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  dispatch;
  logic [STOCK_W-1:0]    head_stock;
  logic [CMD_W-1:0]      head_payload;
  logic [NUM_STOCKS-1:0] head_sel;
  logic [NUM_STOCKS-1:0] slot_idle;
  logic [NUM_STOCKS-1:0] launch;

  logic [NUM_STOCKS-1:0] book_start_q;
  logic [CMD_W-1:0]      book_cmd_q;
  logic                  reject_pulse_q;

  // Occupancy comes from the pointer difference; the extra MSB separates full from empty.
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FIFO_FULL_CNT);
  assign cmd_ready  = ~fifo_full;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign stock_ok = ({1'b0, cmd_stock} < STOCK_LIMIT);
  assign push     = cmd_fire & stock_ok;
  assign reject   = cmd_fire & ~stock_ok;

  assign head_stock   = stock_mem[rd_ptr_q[AW-1:0]];
  assign head_payload = payload_mem[rd_ptr_q[AW-1:0]];

  // The head only leaves when its own book is idle, so later commands never overtake it.
  assign dispatch = ~fifo_empty & (|(slot_idle & head_sel));

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, dispatch};

  always_ff @(posedge clk_in) begin
    if (push) begin
      stock_mem[wr_ptr_q[AW-1:0]]   <= cmd_stock;
      payload_mem[wr_ptr_q[AW-1:0]] <= cmd_payload;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_STOCKS; gi++) begin : g_slot
    logic [1:0] slot_q, slot_d;

    assign head_sel[gi]  = (head_stock == STOCK_W'(gi));
    assign slot_idle[gi] = (slot_q == SLOT_IDLE);
    assign launch[gi]    = dispatch & head_sel[gi];

    // ARM gives the book one cycle to raise busy before it is trusted.
    always_comb begin
      slot_d = slot_q;
      case (slot_q)
        SLOT_IDLE:  if (launch[gi]) slot_d = SLOT_START;
        SLOT_START: slot_d = SLOT_ARM;
        SLOT_ARM:   slot_d = SLOT_RUN;
        SLOT_RUN:   if (!book_busy[gi]) slot_d = SLOT_IDLE;
        default:    slot_d = SLOT_IDLE;
      endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        slot_q <= SLOT_IDLE;
      end else begin
        slot_q <= slot_d;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      book_start_q   <= '0;
      book_cmd_q     <= '0;
      reject_pulse_q <= 1'b0;
    end else begin
      book_start_q   <= launch;
      reject_pulse_q <= reject;
      if (dispatch) begin
        book_cmd_q <= head_payload;
      end
    end
  end

  assign book_start   = book_start_q;
  assign book_cmd     = book_cmd_q;
  assign reject_pulse = reject_pulse_q;
  assign is_busy      = ~fifo_empty | ~(&slot_idle);

`ifdef DISPATCH_STATS_EN
  logic [15:0] dispatch_count_q, dispatch_count_d;
  logic [15:0] reject_count_q, reject_count_d;

  assign dispatch_count_d = (dispatch && dispatch_count_q != 16'hFFFF) ?
                            dispatch_count_q + 16'd1 : dispatch_count_q;
  assign reject_count_d   = (reject && reject_count_q != 16'hFFFF) ?
                            reject_count_q + 16'd1 : reject_count_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dispatch_count_q <= '0;
      reject_count_q   <= '0;
    end else begin
      dispatch_count_q <= dispatch_count_d;
      reject_count_q   <= reject_count_d;
    end
  end

  assign dispatch_count = dispatch_count_q;
  assign reject_count   = reject_count_q;
`else
  assign dispatch_count = '0;
  assign reject_count   = '0;
`endif

endmodule
